// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
// Latency: XLEN/UNROLL+2 cycles per op (accept + CALC + DONE); div-by-zero/overflow take 2 cycles.
// Backpressure: PL_stall holds IF/ID/EX from accept through CALC; released in the DONE cycle.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   flush              pipeline flush; drops any op in flight, beats start
//   start, op          request and funct3 of the M-extension op held in EX
//   rs1_data, rs2_data forwarded operands (stable while PL_stall is high)
//   Rd_i               destination register of the op
//   PL_stall, busy     stage stall request / CALC indicator
//   done, result       one-cycle completion pulse and result (held until the next completion)
//   Rd_o, RegWrite_o   destination latched at accept, write enable on done with Rd_o != 0
module ex_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      Rd_i,
    output logic            PL_stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      Rd_o,
    output logic            RegWrite_o
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic              neg_q;      // final result needs two's-complement negation
    logic [XLEN-1:0]   opnd_q;     // |rs2|: multiplicand or divisor
    logic [2*XLEN-1:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [CW-1:0]     cnt_q;

    // ---------------- accept-time operand conditioning ----------------
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special, neg_in;
    logic [XLEN-1:0] special_res;

    always_comb begin
        // Unsigned rs1 only for MULHU/DIVU/REMU; signed rs2 only for MUL/MULH/DIV/REM.
        a_sgn    = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
        b_sgn    = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_sgn && rs1_data[XLEN-1];
        b_neg    = b_sgn && rs2_data[XLEN-1];
        // |-2^(XLEN-1)| wraps to 2^(XLEN-1), which is exact as an unsigned magnitude.
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div_zero = op[2] && (rs2_data == '0);
        div_ovf  = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        special  = div_zero || div_ovf;
        // Remainder follows the dividend's sign; product and quotient follow the sign difference.
        neg_in   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
        if (div_zero)
            special_res = op[1] ? rs1_data : '1;
        else
            special_res = op[1] ? '0 : rs1_data;
    end

    // ---------------- UNROLL iterations of shift-add / restoring division ----------------
    logic [2*XLEN-1:0] step;
    logic [2*XLEN:0]   sh;
    logic [XLEN:0]     sum;

    always_comb begin
        step = acc_q;
        sh   = '0;
        sum  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                // Shift the next dividend bit into the remainder and try to subtract.
                sh = {step, 1'b0};
                if (sh[2*XLEN:XLEN] >= {1'b0, opnd_q}) begin
                    sh[2*XLEN:XLEN] = sh[2*XLEN:XLEN] - {1'b0, opnd_q};
                    sh[0]           = 1'b1;
                end
                step = sh[2*XLEN-1:0];
            end else begin
                // Add the multiplicand on multiplier LSB, then shift the whole pair right.
                sum  = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, opnd_q} : '0);
                step = {sum, step[XLEN-1:1]};
            end
        end
    end

    // ---------------- final sign fix and result selection ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, calc_res;

    always_comb begin
        prod_fix = neg_q ? -step : step;
        div_sel  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (op_q[2])
            calc_res = neg_q ? -div_sel : div_sel;
        else if (op_q[1:0] == 2'b00)
            calc_res = prod_fix[XLEN-1:0];
        else
            calc_res = prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d    = state_q;
        PL_stall   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                PL_stall = start;
                if (start)
                    state_d = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                PL_stall = 1'b1;
                busy     = 1'b1;
                if (cnt_q == CW'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                // start still high here belongs to the completing instruction.
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush)
            state_d = S_IDLE;
        RegWrite_o = done && (Rd_o != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            result  <= '0;
            Rd_o    <= '0;
        end else begin
            state_q <= state_d;
            if (!flush) begin
                if (state_q == S_IDLE && start) begin
                    op_q   <= op;
                    neg_q  <= neg_in;
                    opnd_q <= b_mag;
                    acc_q  <= {{XLEN{1'b0}}, a_mag};
                    cnt_q  <= CW'(STEPS);
                    Rd_o   <= Rd_i;
                    if (special)
                        result <= special_res;
                end else if (state_q == S_CALC) begin
                    acc_q <= step;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        result <= calc_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_i;

    // Index 0: UNROLL=1 instance, index 1: UNROLL=4 instance.
    logic        start_v [2];
    logic        flush_v [2];
    logic        stall_v [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        regw_v  [2];
    logic [31:0] res_v   [2];
    logic [4:0]  rdo_v   [2];

    logic [31:0] last_exp [2];

    int nvec = 0;
    int nerr = 0;

    ex_muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush_v[0]), .start(start_v[0]), .op(op),
        .rs1_data(rs1), .rs2_data(rs2), .Rd_i(rd_i),
        .PL_stall(stall_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
        .Rd_o(rdo_v[0]), .RegWrite_o(regw_v[0])
    );

    ex_muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush_v[1]), .start(start_v[1]), .op(op),
        .rs1_data(rs1), .rs2_data(rs2), .Rd_i(rd_i),
        .PL_stall(stall_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
        .Rd_o(rdo_v[1]), .RegWrite_o(regw_v[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic [63:0]     w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        w  = '0;
        case (f)
            3'd0: begin p = sa * sb; w = p; return w[31:0]; end
            3'd1: begin p = sa * sb; w = p; return w[63:32]; end
            3'd2: begin p = sa * longint'(ub); w = p; return w[63:32]; end
            3'd3: begin up = ua * ub; w = up; return w[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; w = p; return w[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                up = ua / ub; w = up; return w[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; w = p; return w[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                up = ua % ub; w = up; return w[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one op on instance k, hold start as the pipeline would, check timing and results.
    task automatic run_op(input int k, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input string tag);
        int          cyc, stalls, exp_lat;
        bit          sp;
        logic [31:0] exp_res;
        sp      = is_special(f, a, b);
        exp_lat = sp ? 2 : (32 / (k == 0 ? 1 : 4)) + 2;
        exp_res = ref_res(f, a, b);
        @(negedge clk);
        op = f; rs1 = a; rs2 = b; rd_i = rd; start_v[k] = 1'b1;
        #1;
        cyc    = 1;
        stalls = 0;
        while (!done_v[k] && cyc < 200) begin
            if (stall_v[k]) stalls++;
            if (cyc == 2 && !sp) chk({tag, " busy"}, 64'(busy_v[k]), 64'd1);
            @(negedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat - 1));
        chk({tag, " result"}, 64'(res_v[k]), 64'(exp_res));
        chk({tag, " Rd_o"}, 64'(rdo_v[k]), 64'(rd));
        chk({tag, " RegWrite_o"}, 64'(regw_v[k]), 64'(rd != 5'd0));
        chk({tag, " stall in done"}, 64'(stall_v[k]), 64'd0);
        last_exp[k] = exp_res;
        // start is still high across the DONE edge: must not restart.
        @(negedge clk); #1;
        chk({tag, " done pulse width"}, 64'(done_v[k]), 64'd0);
        chk({tag, " no restart"}, 64'(busy_v[k]), 64'd0);
        chk({tag, " result held"}, 64'(res_v[k]), 64'(exp_res));
        start_v[k] = 1'b0;
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        chk({tag, " PL_stall"}, 64'(stall_v[k]), 64'd0);
        chk({tag, " busy"}, 64'(busy_v[k]), 64'd0);
        chk({tag, " done"}, 64'(done_v[k]), 64'd0);
        chk({tag, " result"}, 64'(res_v[k]), 64'd0);
        chk({tag, " Rd_o"}, 64'(rdo_v[k]), 64'd0);
        chk({tag, " RegWrite_o"}, 64'(regw_v[k]), 64'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        rst = 1'b1; op = '0; rs1 = '0; rs2 = '0; rd_i = '0;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        flush_v[0] = 1'b0; flush_v[1] = 1'b0;
        last_exp[0] = '0; last_exp[1] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals(0, "reset u1");
        check_reset_vals(1, "reset u4");
        rst = 1'b0;

        // Directed corner cases, UNROLL=1.
        run_op(0, 3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  "MUL 7x-3");
        run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, "MULH min^2");
        run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "MULHU max^2");
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2,        5'd8,  "MULHSU -1x2");
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2,        5'd9,  "DIV -7/2");
        run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2,        5'd10, "REM -7%2");
        run_op(0, 3'd5, 32'd100,       32'd7,        5'd11, "DIVU 100/7");
        run_op(0, 3'd7, 32'd100,       32'd7,        5'd12, "REMU 100%7");
        run_op(0, 3'd5, 32'd1234,      32'd0,        5'd13, "DIVU x/0");
        run_op(0, 3'd6, 32'd5,         32'd0,        5'd14, "REM 5%0");
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "DIV ovf");
        run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  "REM ovf");

        // Flush in the 10th CALC cycle.
        @(negedge clk);
        op = 3'd4; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7; rd_i = 5'd3; start_v[0] = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("flush pre busy", 64'(busy_v[0]), 64'd1);
        flush_v[0] = 1'b1; start_v[0] = 1'b0;
        @(negedge clk); #1;
        flush_v[0] = 1'b0;
        chk("flush busy", 64'(busy_v[0]), 64'd0);
        chk("flush PL_stall", 64'(stall_v[0]), 64'd0);
        chk("flush done", 64'(done_v[0]), 64'd0);
        chk("flush RegWrite_o", 64'(regw_v[0]), 64'd0);
        chk("flush result kept", 64'(res_v[0]), 64'(last_exp[0]));
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            chk("flush no late done", 64'(done_v[0]), 64'd0);
        end
        run_op(0, 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd3, "DIV after flush");

        // flush and start together: flush wins.
        @(negedge clk);
        op = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_i = 5'd1;
        start_v[0] = 1'b1; flush_v[0] = 1'b1;
        @(negedge clk); #1;
        chk("flush beats start busy", 64'(busy_v[0]), 64'd0);
        chk("flush beats start done", 64'(done_v[0]), 64'd0);
        start_v[0] = 1'b0; flush_v[0] = 1'b0;

        // Reset mid-operation.
        @(negedge clk);
        op = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_i = 5'd4; start_v[0] = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1; start_v[0] = 1'b0;
        @(negedge clk); #1;
        check_reset_vals(0, "rst midop");
        rst = 1'b0;
        last_exp[0] = '0;

        // Randomized ops, UNROLL=1.
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op(0, f, a, b, rd, "rand u1");
        end

        // UNROLL=4 instance.
        run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd0, "u4 MUL 7x-3 rd0");
        run_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd2, "u4 DIV -7/2");
        run_op(1, 3'd7, 32'd9, 32'd0, 5'd2, "u4 REMU x%0");
        for (int i = 0; i < 15; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            rd = 5'($urandom_range(0, 31));
            run_op(1, f, a, b, rd, "rand u4");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
